uart_core_param: RTL and testbench
==================================

UART_CORE_PARAM -- requirements
Module: uart_core_param

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 500000, line rate in bit/s.
REQ-003 SHALL have parameter RX_OVERSAMPLE, default 16, RX sample ticks per bit; even, 4..16.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame; 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits per frame; 1 or 2.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_Tx_Valid, input, 1, TX word offered.
REQ-010 SHALL have port i_Tx_Byte, input, DATA_BITS, TX word.
REQ-011 SHALL have port o_Tx_Ready, output, 1, transmitter can accept a word.
REQ-012 SHALL have port o_Tx_Data, output, 1, serial line out; idle high.
REQ-013 SHALL have port o_Tx_Active, output, 1, frame in progress.
REQ-014 SHALL have port o_Tx_Done, output, 1, one-cycle pulse at end of frame.
REQ-015 SHALL have port i_Rx_Data, input, 1, serial line in; asynchronous.
REQ-016 SHALL have port i_Loopback, input, 1, internal TX-to-RX loopback enable.
REQ-017 SHALL have port i_Rx_Read, input, 1, consumer takes received word.
REQ-018 SHALL have port o_Rx_Valid, output, 1, received word held.
REQ-019 SHALL have port o_Rx_Byte, output, DATA_BITS, received word.
REQ-020 SHALL have port o_Rx_Parity_Err, output, 1, parity mismatch on the held word.
REQ-021 SHALL have port o_Rx_Frame_Err, output, 1, first stop bit sampled low on the held word.
REQ-022 SHALL have port o_Rx_Overrun, output, 1, sticky: a word was lost; cleared by i_Rx_Read.

Function
REQ-023 SHALL time TX with a counter of BIT_DIV = CLOCK_RATE/BAUD_RATE clk cycles per bit, using truncating integer division.
REQ-024 SHALL generate an RX sample tick every SMP_DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE) clk cycles, as a clock enable only; no derived clocks.
REQ-025 SHALL halt elaboration if SMP_DIV < 1 or any parameter is out of range.
REQ-026 SHALL send frames LSB first: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1); frame length is 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits.
REQ-027 SHALL compute parity as XOR of the data bits for even parity and its inverse for odd parity.
REQ-028 SHALL use TX FSM states IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE, each bit lasting exactly BIT_DIV cycles.
REQ-029 SHALL assert o_Tx_Ready only in IDLE.
REQ-030 SHALL accept a word on a clk edge with i_Tx_Valid&o_Tx_Ready, latch i_Tx_Byte, and drive the start bit from the next cycle.
REQ-031 SHALL pulse o_Tx_Done in the cycle the TX FSM returns to IDLE, with o_Tx_Ready high in that same cycle so back-to-back frames have no gap.
REQ-032 SHALL ignore i_Tx_Byte changes after acceptance.
REQ-033 SHALL pass i_Rx_Data through a 2-flop synchronizer before use.
REQ-034 SHALL take the RX line from the internal TX serial line when i_Loopback=1, with o_Tx_Data forced to 1; i_Loopback SHALL be changed only while both FSMs are idle.
REQ-035 SHALL use RX FSM states IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
REQ-036 SHALL enter START from IDLE on a synchronized high-to-low transition.
REQ-037 SHALL re-sample the line at RX_OVERSAMPLE/2 ticks after entering START, returning to IDLE (false start, no output) if it reads 1.
REQ-038 SHALL sample each data, parity and first stop bit once, every RX_OVERSAMPLE ticks after the start-bit midpoint.
REQ-039 SHALL not check a second stop bit on RX.
REQ-040 SHALL, one cycle after sampling the stop bit, load o_Rx_Byte with the flags and set o_Rx_Valid.
REQ-041 SHALL deliver the word even when a parity or framing error is flagged.
REQ-042 SHALL hold o_Rx_Valid until a cycle with i_Rx_Read=1, which clears o_Rx_Valid next cycle; i_Rx_Read with o_Rx_Valid=0 is ignored.
REQ-043 SHALL, when a new word completes while o_Rx_Valid=1, discard the new word, keep the old word and set o_Rx_Overrun.
REQ-044 SHALL give priority to the new word over the read when completion and i_Rx_Read coincide: the new word is loaded, o_Rx_Valid stays 1 and no overrun occurs.
REQ-045 SHALL after a framing error wait for the line to be high before re-arming start detection.

Reset
REQ-046 SHALL on reset_n low immediately force both FSMs to IDLE, all counters to 0, o_Tx_Data=1, o_Tx_Ready=1, and o_Tx_Active, o_Tx_Done, o_Rx_Valid, all error flags and o_Rx_Overrun to 0.
REQ-047 SHALL reset o_Rx_Byte to 0 and synchronizer flops to 1.
REQ-048 SHALL abort any frame in progress on mid-frame reset, with no o_Tx_Done or o_Rx_Valid afterwards.

Verification
REQ-049 Loopback 8N1, CLOCK_RATE=16000000, BAUD_RATE=500000 (BIT_DIV=32), send 0xA5 -> o_Tx_Done 321 cycles after accept; o_Rx_Valid with o_Rx_Byte=0xA5, no error flags.
REQ-050 DATA_BITS=7, PARITY=2, STOP_BITS=2, external line driving 0x41 with wrong parity -> o_Rx_Byte=0x41, o_Rx_Parity_Err=1.
REQ-051 Two words 0x11 and 0x22 received without i_Rx_Read -> o_Rx_Byte=0x11, o_Rx_Overrun=1; i_Rx_Read clears both.
REQ-052 A 0.25-bit low glitch on i_Rx_Data -> no o_Rx_Valid; FSM back in IDLE.
REQ-053 Stop bit driven 0 with data 0x3C -> o_Rx_Frame_Err=1, o_Rx_Byte=0x3C; the next frame after the line returns high is received cleanly.
REQ-054 reset_n pulsed low mid-DATA on TX -> o_Tx_Data=1, o_Tx_Ready=1 at once; the next accepted word is sent intact.

Source files
------------

// File: rtl/uart_core_param.sv
`timescale 1ns/1ps
// uart_core_param: parameterised UART transmitter and receiver on one clock.
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   i_Tx_Valid/i_Tx_Byte  : word offered to the transmitter (valid/ready)
//   o_Tx_Ready            : transmitter idle and able to accept a word
//   o_Tx_Data             : serial line out, idle high (held high in loopback)
//   o_Tx_Active/o_Tx_Done : frame in progress / one-cycle end-of-frame pulse
//   i_Rx_Data             : asynchronous serial line in
//   i_Loopback            : route the internal TX line into the receiver
//   i_Rx_Read             : consumer takes the held received word
//   o_Rx_Valid/o_Rx_Byte  : held received word
//   o_Rx_Parity_Err       : parity mismatch on the held word
//   o_Rx_Frame_Err        : first stop bit sampled low on the held word
//   o_Rx_Overrun          : sticky, a completed word was dropped
module uart_core_param #(
   parameter int unsigned CLOCK_RATE    = 16000000,
   parameter int unsigned BAUD_RATE     = 500000,
   parameter int unsigned RX_OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned PARITY        = 0,
   parameter int unsigned STOP_BITS     = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_Tx_Valid,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Data,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Done,
   input  logic                 i_Rx_Data,
   input  logic                 i_Loopback,
   input  logic                 i_Rx_Read,
   output logic                 o_Rx_Valid,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Rx_Parity_Err,
   output logic                 o_Rx_Frame_Err,
   output logic                 o_Rx_Overrun
);

   localparam int unsigned BIT_DIV  = CLOCK_RATE / BAUD_RATE;
   localparam int unsigned SMP_DIV  = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
   localparam int unsigned BIT_CW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int unsigned SMP_CW   = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
   localparam int unsigned TICK_CW  = $clog2(RX_OVERSAMPLE);
   localparam int unsigned IDX_CW   = $clog2(DATA_BITS);
   localparam logic        PAR_EN   = (PARITY != 0);
   localparam logic        PAR_ODD  = (PARITY == 2);

   // Refuse to build with unusable rate or frame parameters.
   if (SMP_DIV < 1 || RX_OVERSAMPLE < 4 || RX_OVERSAMPLE > 16 ||
       (RX_OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
      $fatal(1, "uart_core_param: parameter out of range");
   end

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_e;

   // ---------------------------------------------------------------- TX
   tx_state_e            tx_state_q, tx_state_d;
   logic [BIT_CW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [IDX_CW-1:0]    tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_stop_q, tx_stop_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_pin_q, tx_pin_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 tx_active_q, tx_active_d;
   logic                 tx_done_q, tx_done_d;
   logic                 tx_bit_end_c;

   // TX next state; the line value is computed for the next state so the
   // registered line changes on the same edge as the state.
   always_comb begin : tx_next
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_idx_d     = tx_idx_q;
      tx_shreg_d   = tx_shreg_q;
      tx_par_d     = tx_par_q;
      tx_stop_d    = tx_stop_q;
      tx_line_d    = tx_line_q;
      tx_done_d    = 1'b0;
      tx_bit_end_c = (tx_cnt_q == BIT_CW'(BIT_DIV - 1));

      if (tx_state_q != TX_IDLE) begin
         tx_cnt_d = tx_bit_end_c ? '0 : tx_cnt_q + BIT_CW'(1);
      end

      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d  = '0;
            tx_line_d = 1'b1;
            if (i_Tx_Valid) begin
               tx_shreg_d = i_Tx_Byte;
               tx_par_d   = (^i_Tx_Byte) ^ PAR_ODD;
               tx_line_d  = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_bit_end_c) begin
               tx_state_d = TX_DATA;
               tx_idx_d   = '0;
               tx_line_d  = tx_shreg_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end_c) begin
               if (tx_idx_q == IDX_CW'(DATA_BITS - 1)) begin
                  if (PAR_EN) begin
                     tx_state_d = TX_PARITY;
                     tx_line_d  = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_stop_d  = 1'b0;
                     tx_line_d  = 1'b1;
                  end
               end else begin
                  // Shift so the next data bit always sits at index 1.
                  tx_idx_d   = tx_idx_q + IDX_CW'(1);
                  tx_shreg_d = tx_shreg_q >> 1;
                  tx_line_d  = tx_shreg_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end_c) begin
               tx_state_d = TX_STOP;
               tx_stop_d  = 1'b0;
               tx_line_d  = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end_c) begin
               if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                  tx_state_d = TX_IDLE;
                  tx_done_d  = 1'b1;
               end else begin
                  tx_stop_d = 1'b1;
               end
               tx_line_d = 1'b1;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
         end
      endcase

      tx_ready_d  = (tx_state_d == TX_IDLE);
      tx_active_d = ~tx_ready_d;
      tx_pin_d    = i_Loopback | tx_line_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin : tx_regs
      if (!reset_n) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_shreg_q  <= '0;
         tx_par_q    <= 1'b0;
         tx_stop_q   <= 1'b0;
         tx_line_q   <= 1'b1;
         tx_pin_q    <= 1'b1;
         tx_ready_q  <= 1'b1;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         tx_shreg_q  <= tx_shreg_d;
         tx_par_q    <= tx_par_d;
         tx_stop_q   <= tx_stop_d;
         tx_line_q   <= tx_line_d;
         tx_pin_q    <= tx_pin_d;
         tx_ready_q  <= tx_ready_d;
         tx_active_q <= tx_active_d;
         tx_done_q   <= tx_done_d;
      end
   end

   assign o_Tx_Ready  = tx_ready_q;
   assign o_Tx_Data   = tx_pin_q;
   assign o_Tx_Active = tx_active_q;
   assign o_Tx_Done   = tx_done_q;

   // ---------------------------------------------------------------- RX
   rx_state_e            rx_state_q, rx_state_d;
   logic [1:0]           sync_q, sync_d;
   logic                 rx_prev_q, rx_prev_d;
   logic [SMP_CW-1:0]    smp_cnt_q, smp_cnt_d;
   logic [TICK_CW-1:0]   rx_tcnt_q, rx_tcnt_d;
   logic [IDX_CW-1:0]    rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
   logic                 rx_par_q, rx_par_d;
   logic                 rx_stop_q, rx_stop_d;
   logic                 rx_cmpl_q, rx_cmpl_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_ovr_q, rx_ovr_d;
   logic                 rx_bit_c;
   logic                 tick_c;
   logic                 tick_last_c;

   // Line select, 2-flop synchronizer and free-running sample-tick enable.
   always_comb begin : rx_front
      sync_d    = {sync_q[0], (i_Loopback ? tx_line_q : i_Rx_Data)};
      rx_bit_c  = sync_q[1];
      rx_prev_d = rx_bit_c;
      tick_c    = (smp_cnt_q == SMP_CW'(SMP_DIV - 1));
      smp_cnt_d = tick_c ? '0 : smp_cnt_q + SMP_CW'(1);
   end

   // RX next state; every sample point is counted in ticks from the
   // start-bit midpoint. Re-arming needs a fresh high-to-low edge, so a
   // line stuck low after a framing error is never mistaken for a start.
   always_comb begin : rx_next
      rx_state_d  = rx_state_q;
      rx_tcnt_d   = rx_tcnt_q;
      rx_idx_d    = rx_idx_q;
      rx_shreg_d  = rx_shreg_q;
      rx_par_d    = rx_par_q;
      rx_stop_d   = rx_stop_q;
      rx_cmpl_d   = 1'b0;
      tick_last_c = (rx_tcnt_q == TICK_CW'(RX_OVERSAMPLE - 1));

      case (rx_state_q)
         RX_IDLE: begin
            rx_tcnt_d = '0;
            if (rx_prev_q && !rx_bit_c) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (tick_c) begin
               if (rx_tcnt_q == TICK_CW'(RX_OVERSAMPLE / 2 - 1)) begin
                  rx_tcnt_d  = '0;
                  rx_idx_d   = '0;
                  rx_state_d = rx_bit_c ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tcnt_d = rx_tcnt_q + TICK_CW'(1);
               end
            end
         end
         RX_DATA: begin
            if (tick_c) begin
               if (tick_last_c) begin
                  rx_tcnt_d  = '0;
                  rx_shreg_d = {rx_bit_c, rx_shreg_q[DATA_BITS-1:1]};
                  if (rx_idx_q == IDX_CW'(DATA_BITS - 1)) begin
                     rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_idx_d = rx_idx_q + IDX_CW'(1);
                  end
               end else begin
                  rx_tcnt_d = rx_tcnt_q + TICK_CW'(1);
               end
            end
         end
         RX_PARITY: begin
            if (tick_c) begin
               if (tick_last_c) begin
                  rx_tcnt_d  = '0;
                  rx_par_d   = rx_bit_c;
                  rx_state_d = RX_STOP;
               end else begin
                  rx_tcnt_d = rx_tcnt_q + TICK_CW'(1);
               end
            end
         end
         RX_STOP: begin
            if (tick_c) begin
               if (tick_last_c) begin
                  rx_tcnt_d  = '0;
                  rx_stop_d  = rx_bit_c;
                  rx_cmpl_d  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_tcnt_d = rx_tcnt_q + TICK_CW'(1);
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Held-word register: a completing word beats a simultaneous read,
   // otherwise a completion while a word is held is dropped as overrun.
   always_comb begin : rx_hold
      rx_valid_d = rx_valid_q;
      rx_byte_d  = rx_byte_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovr_d   = rx_ovr_q;

      if (i_Rx_Read && rx_valid_q) begin
         rx_valid_d = 1'b0;
         rx_perr_d  = 1'b0;
         rx_ferr_d  = 1'b0;
         rx_ovr_d   = 1'b0;
      end

      if (rx_cmpl_q) begin
         if (!rx_valid_q || i_Rx_Read) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shreg_q;
            rx_perr_d  = PAR_EN & ((^rx_shreg_q) ^ rx_par_q ^ PAR_ODD);
            rx_ferr_d  = ~rx_stop_q;
         end else begin
            rx_ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : rx_regs
      if (!reset_n) begin
         rx_state_q <= RX_IDLE;
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         smp_cnt_q  <= '0;
         rx_tcnt_q  <= '0;
         rx_idx_q   <= '0;
         rx_shreg_q <= '0;
         rx_par_q   <= 1'b0;
         rx_stop_q  <= 1'b0;
         rx_cmpl_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_byte_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         sync_q     <= sync_d;
         rx_prev_q  <= rx_prev_d;
         smp_cnt_q  <= smp_cnt_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shreg_q <= rx_shreg_d;
         rx_par_q   <= rx_par_d;
         rx_stop_q  <= rx_stop_d;
         rx_cmpl_q  <= rx_cmpl_d;
         rx_valid_q <= rx_valid_d;
         rx_byte_q  <= rx_byte_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign o_Rx_Valid      = rx_valid_q;
   assign o_Rx_Byte       = rx_byte_q;
   assign o_Rx_Parity_Err = rx_perr_q;
   assign o_Rx_Frame_Err  = rx_ferr_q;
   assign o_Rx_Overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
`timescale 1ns/1ps
// Bench for uart_core_param: an 8N1 instance (a_*) and a 7-bit odd-parity
// two-stop instance (b_*), checked by queue scoreboards and monitors.
module tb_uart_core_param;

   localparam int BIT_CYC  = 32;            // 16 MHz / 500 kbit/s
   localparam int A_BITS   = 1 + 8 + 0 + 1;
   localparam int B_BITS   = 1 + 7 + 1 + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A signals
   logic       a_txv = 1'b0;
   logic [7:0] a_txb = '0;
   logic       a_rdy, a_txd, a_act, a_done;
   logic       a_rx_drv = 1'b1, a_ext = 1'b0, a_lb = 1'b0, a_rx_in;
   logic       a_mon_rd = 1'b0, a_man_rd = 1'b0, a_rd, a_mon_en = 1'b1;
   logic       a_valid, a_pe, a_fe, a_ovr;
   logic [7:0] a_byte;

   // instance B signals
   logic       b_txv = 1'b0;
   logic [6:0] b_txb = '0;
   logic       b_rdy, b_txd, b_act, b_done;
   logic       b_rx_drv = 1'b1, b_ext = 1'b0, b_rx_in;
   logic       b_mon_rd = 1'b0;
   logic       b_valid, b_pe, b_fe, b_ovr;
   logic [6:0] b_byte;

   assign a_rx_in = a_ext ? a_txd : a_rx_drv;
   assign b_rx_in = b_ext ? b_txd : b_rx_drv;
   assign a_rd    = a_mon_rd | a_man_rd;

   uart_core_param dut_a (
      .clk(clk), .reset_n(rst_n),
      .i_Tx_Valid(a_txv), .i_Tx_Byte(a_txb), .o_Tx_Ready(a_rdy),
      .o_Tx_Data(a_txd), .o_Tx_Active(a_act), .o_Tx_Done(a_done),
      .i_Rx_Data(a_rx_in), .i_Loopback(a_lb), .i_Rx_Read(a_rd),
      .o_Rx_Valid(a_valid), .o_Rx_Byte(a_byte), .o_Rx_Parity_Err(a_pe),
      .o_Rx_Frame_Err(a_fe), .o_Rx_Overrun(a_ovr)
   );

   uart_core_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset_n(rst_n),
      .i_Tx_Valid(b_txv), .i_Tx_Byte(b_txb), .o_Tx_Ready(b_rdy),
      .o_Tx_Data(b_txd), .o_Tx_Active(b_act), .o_Tx_Done(b_done),
      .i_Rx_Data(b_rx_in), .i_Loopback(1'b0), .i_Rx_Read(b_mon_rd),
      .o_Rx_Valid(b_valid), .o_Rx_Byte(b_byte), .o_Rx_Parity_Err(b_pe),
      .o_Rx_Frame_Err(b_fe), .o_Rx_Overrun(b_ovr)
   );

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Number of ones in the low n bits, modulo 2.
   function automatic logic ones_odd(input logic [8:0] d, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (d[i]) c++;
      return 1'(c % 2);
   endfunction

   task automatic push(input int which, input logic [8:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d = d; e.pe = pe; e.fe = fe;
      if (which == 0) qa.push_back(e); else qb.push_back(e);
   endtask

   // Monitor A: every presented word is compared with the queue head, then read.
   always @(negedge clk) begin
      exp_t e;
      if (a_mon_rd) a_mon_rd = 1'b0;
      else if (rst_n && a_mon_en && a_valid) begin
         if (qa.size() == 0) begin
            tests++; fails++;
            $display("FAIL a_unexpected_word: got 0x%0h, expected no word", a_byte);
         end else begin
            e = qa.pop_front();
            check("a_rx_byte", 32'(a_byte), 32'(e.d));
            check("a_rx_parity_err", 32'(a_pe), 32'(e.pe));
            check("a_rx_frame_err", 32'(a_fe), 32'(e.fe));
            check("a_rx_overrun", 32'(a_ovr), 32'(0));
         end
         a_mon_rd = 1'b1;
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      exp_t e;
      if (b_mon_rd) b_mon_rd = 1'b0;
      else if (rst_n && b_valid) begin
         if (qb.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_unexpected_word: got 0x%0h, expected no word", b_byte);
         end else begin
            e = qb.pop_front();
            check("b_rx_byte", 32'(b_byte), 32'(e.d));
            check("b_rx_parity_err", 32'(b_pe), 32'(e.pe));
            check("b_rx_frame_err", 32'(b_fe), 32'(e.fe));
            check("b_rx_overrun", 32'(b_ovr), 32'(0));
         end
         b_mon_rd = 1'b1;
      end
   end

   task automatic set_line(input int which, input logic v);
      if (which == 0) a_rx_drv = v; else b_rx_drv = v;
   endtask

   task automatic hold_bit(input int which, input logic v);
      set_line(which, v);
      repeat (BIT_CYC) @(negedge clk);
   endtask

   // Bench-driven serial frame followed by one idle bit time.
   task automatic drive_frame(input int which, input logic [8:0] d, input int nbits,
                              input logic has_par, input logic par,
                              input logic stop_low, input int nstop);
      hold_bit(which, 1'b0);
      for (int i = 0; i < nbits; i++) hold_bit(which, d[i]);
      if (has_par) hold_bit(which, par);
      for (int s = 0; s < nstop; s++) hold_bit(which, (s == 0) ? ~stop_low : 1'b1);
      hold_bit(which, 1'b1);
   endtask

   // Offer a word when ready (called at a negedge), then time accept-to-done.
   // Returns in the done cycle, so a following call is accepted without a gap.
   task automatic tx_send(input int which, input logic [8:0] d);
      int n = 0;
      int exp_lat;
      logic saw_low = 1'b0;
      exp_lat = ((which == 0) ? A_BITS : B_BITS) * BIT_CYC + 1;
      while (((which == 0) ? a_rdy : b_rdy) !== 1'b1 && n < 2000) begin
         @(negedge clk); n++;
      end
      check("tx_ready_wait_bounded", 32'(n < 2000), 32'(1));
      if (which == 0) begin a_txv = 1'b1; a_txb = d[7:0]; end
      else begin b_txv = 1'b1; b_txb = d[6:0]; end
      @(posedge clk);
      #1;
      a_txv = 1'b0; b_txv = 1'b0;
      a_txb = ~a_txb; b_txb = ~b_txb;   // changes after acceptance must not matter
      n = 0;
      while (n < 2000) begin
         @(negedge clk); n++;
         if (n == 1) begin
            check("tx_active_in_frame", 32'((which == 0) ? a_act : b_act), 32'(1));
            check("tx_not_ready_in_frame", 32'((which == 0) ? a_rdy : b_rdy), 32'(0));
         end
         if (which == 0 && a_txd == 1'b0) saw_low = 1'b1;
         if (((which == 0) ? a_done : b_done) == 1'b1) break;
      end
      check("tx_done_latency", 32'(n), 32'(exp_lat));
      check("tx_ready_with_done", 32'((which == 0) ? a_rdy : b_rdy), 32'(1));
      if (which == 0 && a_lb) check("a_loopback_line_high", 32'(saw_low), 32'(0));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4000 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("a_scoreboard_drained", 32'(qa.size()), 32'(0));
      check("b_scoreboard_drained", 32'(qb.size()), 32'(0));
   endtask

   initial begin
      logic [8:0] d;
      logic       wrong, ferr, p;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_a_tx_data", 32'(a_txd), 32'(1));
      check("rst_a_tx_ready", 32'(a_rdy), 32'(1));
      check("rst_a_tx_active", 32'(a_act), 32'(0));
      check("rst_a_tx_done", 32'(a_done), 32'(0));
      check("rst_a_rx_valid", 32'(a_valid), 32'(0));
      check("rst_a_rx_byte", 32'(a_byte), 32'(0));
      check("rst_a_flags", 32'({a_pe, a_fe, a_ovr}), 32'(0));
      check("rst_b_tx_data", 32'(b_txd), 32'(1));
      check("rst_b_tx_ready", 32'(b_rdy), 32'(1));
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // internal loopback, 0xA5 then random back-to-back words
      a_lb = 1'b1;
      push(0, 9'h0A5, 1'b0, 1'b0);
      tx_send(0, 9'h0A5);
      for (int k = 0; k < 6; k++) begin
         d = 9'($urandom_range(0, 255));
         push(0, d, 1'b0, 1'b0);
         tx_send(0, d);
      end
      wait_drain();
      a_lb = 1'b0;

      // external line fed back from o_Tx_Data
      a_ext = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         d = 9'($urandom_range(0, 255));
         push(0, d, 1'b0, 1'b0);
         tx_send(0, d);
      end
      wait_drain();
      a_ext = 1'b0;

      // bench-driven random frames, a framing error on 0x3C, then a clean frame
      for (int k = 0; k < 5; k++) begin
         d = 9'($urandom_range(0, 255));
         push(0, d, 1'b0, 1'b0);
         drive_frame(0, d, 8, 1'b0, 1'b0, 1'b0, 1);
      end
      push(0, 9'h03C, 1'b0, 1'b1);
      drive_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1);
      d = 9'($urandom_range(0, 255));
      push(0, d, 1'b0, 1'b0);
      drive_frame(0, d, 8, 1'b0, 1'b0, 1'b0, 1);
      wait_drain();

      // quarter-bit glitch must not produce a word; next frame still clean
      set_line(0, 1'b0);
      repeat (BIT_CYC / 4) @(negedge clk);
      set_line(0, 1'b1);
      repeat (3 * BIT_CYC) @(negedge clk);
      check("glitch_no_valid", 32'(a_valid), 32'(0));
      push(0, 9'h096, 1'b0, 1'b0);
      drive_frame(0, 9'h096, 8, 1'b0, 1'b0, 1'b0, 1);
      wait_drain();

      // overrun: two words without a read keep the first
      a_mon_en = 1'b0;
      drive_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1);
      drive_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1);
      check("ovr_valid", 32'(a_valid), 32'(1));
      check("ovr_byte_kept", 32'(a_byte), 32'h11);
      check("ovr_flag", 32'(a_ovr), 32'(1));
      a_man_rd = 1'b1;
      @(negedge clk);
      a_man_rd = 1'b0;
      check("ovr_read_clears_valid", 32'(a_valid), 32'(0));
      check("ovr_read_clears_flag", 32'(a_ovr), 32'(0));
      a_mon_en = 1'b1;

      // B: 0x41 with wrong odd parity, then random parity/stop faults
      p = ones_odd(9'h041, 7);                // wrong odd-parity bit equals the data parity
      push(1, 9'h041, 1'b1, 1'b0);
      drive_frame(1, 9'h041, 7, 1'b1, p, 1'b0, 2);
      for (int k = 0; k < 8; k++) begin
         d     = 9'($urandom_range(0, 127));
         wrong = 1'($urandom_range(0, 1));
         ferr  = ($urandom_range(0, 3) == 0);
         p     = wrong ? ones_odd(d, 7) : ~ones_odd(d, 7);
         push(1, d, wrong, ferr);
         drive_frame(1, d, 7, 1'b1, p, ferr, 2);
      end
      wait_drain();

      // B transmitter through the external line
      b_ext = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         d = 9'($urandom_range(0, 127));
         push(1, d, 1'b0, 1'b0);
         tx_send(1, d);
      end
      wait_drain();
      b_ext = 1'b0;

      // reset in the middle of a TX data bit aborts both TX and RX frames
      a_ext = 1'b1;
      @(negedge clk);
      a_txv = 1'b1; a_txb = 8'h5A;
      @(posedge clk);
      #1 a_txv = 1'b0;
      repeat (4 * BIT_CYC) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_data", 32'(a_txd), 32'(1));
      check("midrst_tx_ready", 32'(a_rdy), 32'(1));
      check("midrst_tx_active", 32'(a_act), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_done", 32'(a_done), 32'(0));
      push(0, 9'h0C3, 1'b0, 1'b0);
      tx_send(0, 9'h0C3);
      wait_drain();
      a_ext = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
